// File: rtl/branch_target_unit_if.sv
// Request/response bundle for branch_target_unit.
// With BTU_RAS_EN defined the bundle also carries pred_target and ras_empty.
interface branch_target_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [WIDTH-1:0] pc_id_ex;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] rs_val;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] pc_branch_target;
    logic [WIDTH-1:0] link_addr;
    logic             misaligned;
`ifdef BTU_RAS_EN
    logic [WIDTH-1:0] pred_target;
    logic             ras_empty;

    modport master (
        output in_valid, mode, pc_id_ex, Y, rs_val, flush, out_ready,
        input  in_ready, out_valid, pc_branch_target, link_addr, misaligned,
               pred_target, ras_empty
    );
    modport slave (
        input  in_valid, mode, pc_id_ex, Y, rs_val, flush, out_ready,
        output in_ready, out_valid, pc_branch_target, link_addr, misaligned,
               pred_target, ras_empty
    );
`else
    modport master (
        output in_valid, mode, pc_id_ex, Y, rs_val, flush, out_ready,
        input  in_ready, out_valid, pc_branch_target, link_addr, misaligned
    );
    modport slave (
        input  in_valid, mode, pc_id_ex, Y, rs_val, flush, out_ready,
        output in_ready, out_valid, pc_branch_target, link_addr, misaligned
    );
`endif
endinterface

// File: rtl/branch_target_unit.sv
// Branch/jump target computation with a one-deep registered output stage.
// Optional return-address stack enabled by defining BTU_RAS_EN.
module branch_target_unit #(
    parameter int WIDTH     = 32,
    parameter int OFF_W     = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    branch_target_unit_if.slave bus
);
    localparam logic [1:0] MODE_BRANCH = 2'b00;
    localparam logic [1:0] MODE_JUMP   = 2'b01;
    localparam logic [1:0] MODE_JR     = 2'b10;
    localparam logic [1:0] MODE_JAL    = 2'b11;

    logic [WIDTH-1:0] link_w;
    logic [WIDTH-1:0] off_ext;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] jmp_target;
    logic [WIDTH-1:0] target_w;
    logic             accept;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] link_q, link_d;
    logic             misaligned_q, misaligned_d;

    // Upper Y bits only matter for JR-free modes up to bit 25.
    logic unused_y_bits;
    assign unused_y_bits = ^bus.Y[WIDTH-1:26];

    always_comb begin
        link_w     = bus.pc_id_ex + WIDTH'(4);
        off_ext    = {{(WIDTH-OFF_W){bus.Y[OFF_W-1]}}, bus.Y[OFF_W-1:0]};
        br_target  = link_w + (off_ext << 2);
        jmp_target = {link_w[WIDTH-1:28], bus.Y[25:0], 2'b00};
        case (bus.mode)
            MODE_BRANCH: target_w = br_target;
            MODE_JR:     target_w = bus.rs_val;
            default:     target_w = jmp_target;
        endcase
    end

    assign bus.in_ready = !rst && !bus.flush && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Flush wins over everything; accepted requests overwrite the held slot.
    always_comb begin
        out_valid_d  = out_valid_q;
        target_d     = target_q;
        link_d       = link_q;
        misaligned_d = misaligned_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            target_d     = target_w;
            link_d       = link_w;
            misaligned_d = |target_w[1:0];
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            target_q     <= '0;
            link_q       <= '0;
            misaligned_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            target_q     <= target_d;
            link_q       <= link_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.out_valid        = out_valid_q;
    assign bus.pc_branch_target = target_q;
    assign bus.link_addr        = link_q;
    assign bus.misaligned       = misaligned_q;

`ifdef BTU_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [WIDTH-1:0] ras_rd_q;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ras_hit_q, ras_hit_d;
    logic             ras_empty_q, ras_empty_d;
    logic             ras_push;
    logic             ras_pop;

    // ptr_q points at the next free slot; the top of stack sits at ptr_q-1.
    always_comb begin
        ras_push    = accept && (bus.mode == MODE_JAL);
        ras_pop     = accept && (bus.mode == MODE_JR);
        ptr_d       = ptr_q;
        count_d     = count_q;
        ras_hit_d   = ras_hit_q;
        ras_empty_d = ras_empty_q;
        if (accept) begin
            ras_hit_d   = ras_pop && (count_q != '0);
            ras_empty_d = ras_pop && (count_q == '0);
        end
        if (ras_push) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (count_q != CNT_W'(RAS_DEPTH)) count_d = count_q + CNT_W'(1);
        end else if (ras_pop && (count_q != '0)) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            count_q     <= '0;
            ras_hit_q   <= 1'b0;
            ras_empty_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            ras_hit_q   <= ras_hit_d;
            ras_empty_q <= ras_empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_push) ras_mem[ptr_q] <= link_w;
        if (ras_pop)  ras_rd_q <= ras_mem[ptr_q - PTR_W'(1)];
    end

    assign bus.pred_target = ras_hit_q ? ras_rd_q : '0;
    assign bus.ras_empty   = ras_empty_q;
`else
    logic unused_ras_cfg;
    assign unused_ras_cfg = (RAS_DEPTH > 0);
`endif
endmodule

// File: tb/tb_branch_target_unit.sv
// Scoreboard bench for branch_target_unit (default build, BTU_RAS_EN undefined).
module tb_branch_target_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_target_unit_if #(.WIDTH(32)) bus ();

    branch_target_unit #(.WIDTH(32), .OFF_W(16), .RAS_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] link;
        logic        mis;
        logic [1:0]  mode;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   zero_exp = 1'b1;

    // Target rules computed with plain 64-bit arithmetic.
    function automatic exp_t ref_model(logic [1:0] m, logic [31:0] pc, logic [31:0] y, logic [31:0] rs);
        exp_t   e;
        longint p4, off, t;
        p4 = (longint'(pc) + 4) & 64'hFFFF_FFFF;
        case (m)
            2'd0: begin
                off = $signed(y[15:0]);
                t   = (p4 + off * 4) & 64'hFFFF_FFFF;
            end
            2'd2:    t = longint'(rs);
            default: t = (p4 & 64'hF000_0000) | ((longint'(y) & 64'h03FF_FFFF) * 4);
        endcase
        e.tgt  = t[31:0];
        e.link = p4[31:0];
        e.mis  = (t % 4) != 0;
        e.mode = m;
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard bookkeeping at the active edge (DUT state read before it updates).
    always @(posedge clk) begin : scoreboard
        bit   exp_rdy;
        exp_t e;
        exp_rdy = !rst && !bus.flush && (sb_q.size() == 0 || bus.out_ready);
        if (rst) begin
            sb_q.delete();
            zero_exp = 1'b1;
        end else if (bus.flush) begin
            sb_q.delete();
        end else begin
            if (sb_q.size() != 0 && bus.out_ready) begin
                e = sb_q.pop_front();
                $display("txn mode=%0d target=%h link=%h misaligned=%0d", e.mode, e.tgt, e.link, e.mis);
            end
            if (bus.in_valid && exp_rdy) begin
                sb_q.push_back(ref_model(bus.mode, bus.pc_id_ex, bus.Y, bus.rs_val));
                zero_exp = 1'b0;
            end
        end
    end

    // Monitor on the opposite edge compares what the DUT presents.
    always @(negedge clk) begin : monitor
        bit exp_v;
        bit exp_rdy;
        exp_v   = sb_q.size() != 0;
        exp_rdy = !rst && !bus.flush && (!exp_v || bus.out_ready);
        check("out_valid", 32'(bus.out_valid), 32'(exp_v));
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (exp_v) begin
            check("target", bus.pc_branch_target, sb_q[0].tgt);
            check("link_addr", bus.link_addr, sb_q[0].link);
            check("misaligned", 32'(bus.misaligned), 32'(sb_q[0].mis));
        end else if (zero_exp) begin
            check("rst_target", bus.pc_branch_target, 32'h0);
            check("rst_link", bus.link_addr, 32'h0);
            check("rst_misaligned", 32'(bus.misaligned), 32'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(logic [1:0] m, logic [31:0] pc, logic [31:0] y, logic [31:0] rs);
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.pc_id_ex = pc;
        bus.Y        = y;
        bus.rs_val   = rs;
    endtask

    task automatic rand_req();
        logic [31:0] pc;
        pc = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 9) == 0) pc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
        if ($urandom_range(0, 9) == 0) pc = $urandom & 32'h0000_00FC;
        set_req(2'($urandom_range(0, 3)), pc, $urandom, $urandom);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mode      = 2'd0;
        bus.pc_id_ex  = '0;
        bus.Y         = '0;
        bus.rs_val    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // BRANCH with offset -1: target equals pc, result one cycle later.
        set_req(2'd0, 32'h0040_0000, 32'h0000_FFFF, 32'h0);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("dir_branch_valid", 32'(bus.out_valid), 32'h1);
        check("dir_branch_target", bus.pc_branch_target, 32'h0040_0000);
        check("dir_branch_mis", 32'(bus.misaligned), 32'h0);
        step();

        // JUMP
        set_req(2'd1, 32'h1000_0000, 32'h0000_0100, 32'h0);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("dir_jump_target", bus.pc_branch_target, 32'h1000_0400);
        check("dir_jump_link", bus.link_addr, 32'h1000_0004);
        step();

        // Backpressure: hold three cycles, then one in/one out per cycle.
        bus.out_ready = 1'b0;
        rand_req();
        step();
        rand_req();
        repeat (3) begin
            @(negedge clk);
            check("dir_bp_in_ready", 32'(bus.in_ready), 32'h0);
            step();
        end
        bus.out_ready = 1'b1;
        repeat (3) begin
            rand_req();
            step();
        end

        // Flush with a held result and a pending request.
        bus.out_ready = 1'b0;
        rand_req();
        bus.flush = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("dir_flush_valid", 32'(bus.out_valid), 32'h0);
        step();

        // Reset while a result is held.
        rand_req();
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        @(negedge clk);
        check("dir_rst_valid", 32'(bus.out_valid), 32'h0);
        check("dir_rst_target", bus.pc_branch_target, 32'h0);
        check("dir_rst_link", bus.link_addr, 32'h0);
        check("dir_rst_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        rst = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 70) rand_req();
            else bus.in_valid = 1'b0;
            bus.out_ready = ($urandom_range(0, 99) < 70);
            bus.flush     = ($urandom_range(0, 99) < 5);
            rst           = ($urandom_range(0, 99) < 2);
            step();
        end

        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_target_unit.md
BRANCH_TARGET_UNIT -- requirements
Module: branch_target_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32; address/data width, legal values 32..64.
REQ-002 SHALL have parameter OFF_W, default 16; branch offset field width, legal values 8..26.
REQ-003 SHALL have parameter RAS_DEPTH, default 4; return-stack entries, power of two, 2..16.
REQ-004 SHALL use one clock and a synchronous, active-high reset; no other clock or reset.
REQ-005 SHALL have port clk, input, 1; rising-edge clock.
REQ-006 SHALL have port rst, input, 1; synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1; request present.
REQ-008 SHALL have port in_ready, output, 1; request accepted when in_valid&&in_ready at clk edge.
REQ-009 SHALL have port mode, input, 2; 00 BRANCH, 01 JUMP, 10 JR, 11 JAL.
REQ-010 SHALL have port pc_id_ex, input, WIDTH; PC of the instruction in ID/EX.
REQ-011 SHALL have port Y, input, WIDTH; immediate/index field, bits used per mode.
REQ-012 SHALL have port rs_val, input, WIDTH; register operand for JR.
REQ-013 SHALL have port flush, input, 1; discard held result and block acceptance this cycle.
REQ-014 SHALL have port out_valid, output, 1; result held.
REQ-015 SHALL have port out_ready, input, 1; consumer takes result when out_valid&&out_ready.
REQ-016 SHALL have port pc_branch_target, output, WIDTH; computed target.
REQ-017 SHALL have port link_addr, output, WIDTH; pc_id_ex+4 of the held op.
REQ-018 SHALL have port misaligned, output, 1; target[1:0]!=0.

Function
REQ-019 SHALL compute BRANCH target = pc_id_ex + 4 + (sign-extend(Y[OFF_W-1:0]) << 2), modulo 2^WIDTH.
REQ-020 SHALL compute JUMP/JAL target = {(pc_id_ex+4)[WIDTH-1:28], Y[25:0], 2'b00}.
REQ-021 SHALL compute JR target = rs_val unmodified.
REQ-022 SHALL register all results: latency exactly one cycle from acceptance to out_valid=1.
REQ-023 SHALL drive in_ready = !flush && (!out_valid || out_ready), combinationally.
REQ-024 SHALL hold pc_branch_target, link_addr, misaligned and out_valid stable while out_valid&&!out_ready&&!flush.
REQ-025 SHALL, on back-to-back acceptance with out_ready=1, present a new result every cycle with no bubble.
REQ-026 SHALL clear out_valid at the edge where flush=1; flush has priority over any handshake that cycle.
REQ-027 SHALL clear out_valid when result consumed and no new request accepted.
REQ-028 SHALL wrap carry silently on address overflow; no flag raised.

Reset
REQ-029 SHALL, when rst=1 at clk edge, set out_valid=0, pc_branch_target=0, link_addr=0, misaligned=0, RAS pointer and count=0.
REQ-030 SHALL drive in_ready=0 while rst=1; rst has priority over flush and handshakes.
REQ-031 SHALL discard any held result if rst asserts mid-operation; no output reappears after release.

Configuration
REQ-032 SHALL, with macro BTU_RAS_EN defined, include a RAS_DEPTH-entry circular return-address stack and output pred_target (WIDTH) plus ras_empty (1).
REQ-033 SHALL, with BTU_RAS_EN, push link_addr on each accepted JAL; on full, overwrite oldest entry, count saturates at RAS_DEPTH.
REQ-034 SHALL, with BTU_RAS_EN, on each accepted JR pop the top into pred_target registered with the result; on empty, pred_target=0, ras_empty=1, pointer unchanged.
REQ-035 SHALL, with BTU_RAS_EN, leave the RAS unmodified in flush cycles (no acceptance occurs).
REQ-036 SHALL, without BTU_RAS_EN, contain no stack storage and omit pred_target and ras_empty ports.

Verification
REQ-037 SHALL cover BRANCH: pc_id_ex=0x00400000, Y=0xFFFF -> target 0x00400000, misaligned=0, one cycle later.
REQ-038 SHALL cover JUMP: pc_id_ex=0x1000_0000, Y=0x0000_0100 -> target 0x1000_0400, link_addr 0x1000_0004.
REQ-039 SHALL cover backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, then one consumption and one acceptance per cycle.
REQ-040 SHALL cover flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, request not taken, RAS count unchanged.
REQ-041 SHALL cover BTU_RAS_EN, RAS_DEPTH=4: 5 JALs then 5 JRs -> last 4 links popped LIFO, fifth JR gives pred_target=0, ras_empty=1.
REQ-042 SHALL cover rst asserted while out_valid=1 -> out_valid=0, all outputs 0 next cycle, in_ready=0 during rst.
